// File: rtl/dnn_pkg.sv
// Shared defaults and FSM state type for the DNN result argmax block.
package dnn_pkg;

  localparam int DNN_DATA_WIDTH  = 9;
  localparam int DNN_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/argmax_top2_update.sv
// One step of a running top-2 search: folds score x (at index idx) into
// the current best / best_idx / second triple. Ties never displace the
// incumbent, so the lowest index wins among equal maxima.
module argmax_top2_update
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = DNN_DATA_WIDTH,
  parameter int IDX_WIDTH  = $clog2(DNN_NUM_CLASSES)
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic        [IDX_WIDTH-1:0]  idx,
  input  logic signed [DATA_WIDTH-1:0] best,
  input  logic        [IDX_WIDTH-1:0]  best_idx,
  input  logic signed [DATA_WIDTH-1:0] second,
  output logic signed [DATA_WIDTH-1:0] new_best,
  output logic        [IDX_WIDTH-1:0]  new_best_idx,
  output logic signed [DATA_WIDTH-1:0] new_second
);

  // Strict comparisons: a new maximum demotes the old best to second.
  always_comb begin
    new_best     = best;
    new_best_idx = best_idx;
    new_second   = second;
    if (x > best) begin
      new_second   = best;
      new_best     = x;
      new_best_idx = idx;
    end else if (x > second) begin
      new_second = x;
    end
  end

endmodule

// File: rtl/dnn_result_argmax.sv
// Captures a class-score vector from the inference engine, scans it one
// element per cycle for the maximum and runner-up, and holds class, score
// and margin until the next vector or a clear. The captured vector can be
// read back one element at a time through rd_idx/rd_data.
module dnn_result_argmax
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DNN_DATA_WIDTH,
  parameter int NUM_CLASSES = DNN_NUM_CLASSES,
  parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               in_valid,
  // Element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH], two's complement.
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0]  in_vec,
  output logic                               busy,
  output logic                               res_valid,
  output logic [IDX_WIDTH-1:0]               res_class,
  output logic signed [DATA_WIDTH-1:0]       res_score,
  output logic [DATA_WIDTH:0]                res_margin,
  output logic                               in_drop,
  input  logic [IDX_WIDTH-1:0]               rd_idx,
  output logic signed [DATA_WIDTH-1:0]       rd_data
);

  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0]         LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_e                       state_q, state_d;
  logic [IDX_WIDTH-1:0]         cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic [IDX_WIDTH-1:0]         best_idx_q, best_idx_d;
  logic signed [DATA_WIDTH-1:0] second_q, second_d;
  logic                         res_valid_q, res_valid_d;
  logic [IDX_WIDTH-1:0]         res_class_q, res_class_d;
  logic signed [DATA_WIDTH-1:0] res_score_q, res_score_d;
  logic [DATA_WIDTH:0]          res_margin_q, res_margin_d;
  logic                         drop_q, drop_d;
  logic signed [DATA_WIDTH-1:0] rd_data_q;

  logic signed [DATA_WIDTH-1:0] in_elem [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] vec_q   [NUM_CLASSES];

  logic signed [DATA_WIDTH-1:0] upd_best, upd_second;
  logic [IDX_WIDTH-1:0]         upd_best_idx;
  logic [DATA_WIDTH:0]          margin_w;
  logic                         capture;

  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
    assign in_elem[gi] = in_vec[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // A new vector is accepted only outside SCAN, and a clear discards it.
  assign capture = in_valid && !clear && (state_q != SCAN);

  argmax_top2_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_update (
    .x            (vec_q[cnt_q]),
    .idx          (cnt_q),
    .best         (best_q),
    .best_idx     (best_idx_q),
    .second       (second_q),
    .new_best     (upd_best),
    .new_best_idx (upd_best_idx),
    .new_second   (upd_second)
  );

  // Sign-extend by one bit so best minus second can span the full range.
  assign margin_w = {upd_best[DATA_WIDTH-1], upd_best} - {upd_second[DATA_WIDTH-1], upd_second};

  // Next-state and datapath decisions for the IDLE/SCAN/HOLD controller.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    second_d     = second_q;
    res_valid_d  = res_valid_q;
    res_class_d  = res_class_q;
    res_score_d  = res_score_q;
    res_margin_d = res_margin_q;
    drop_d       = drop_q;
    if (clear) begin
      state_d      = IDLE;
      res_valid_d  = 1'b0;
      res_class_d  = '0;
      res_score_d  = '0;
      res_margin_d = '0;
      drop_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          if (in_valid) begin
            state_d     = SCAN;
            cnt_d       = IDX_WIDTH'(1);
            best_d      = in_elem[0];
            best_idx_d  = '0;
            second_d    = MOST_NEG;
            res_valid_d = 1'b0;
          end
        end
        SCAN: begin
          if (in_valid) drop_d = 1'b1;
          best_d     = upd_best;
          best_idx_d = upd_best_idx;
          second_d   = upd_second;
          if (cnt_q == LAST_IDX) begin
            state_d      = HOLD;
            res_valid_d  = 1'b1;
            res_class_d  = upd_best_idx;
            res_score_d  = upd_best;
            res_margin_d = margin_w;
          end else begin
            cnt_d = cnt_q + IDX_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      second_q     <= '0;
      res_valid_q  <= 1'b0;
      res_class_q  <= '0;
      res_score_q  <= '0;
      res_margin_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      second_q     <= second_d;
      res_valid_q  <= res_valid_d;
      res_class_q  <= res_class_d;
      res_score_q  <= res_score_d;
      res_margin_q <= res_margin_d;
      drop_q       <= drop_d;
    end
  end

  // Score buffer: zeroed by reset, kept across clear, loaded on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) vec_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_CLASSES; i++) vec_q[i] <= in_elem[i];
    end
  end

  // Registered readout; out-of-range indices fall back to element 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (int'(rd_idx) < NUM_CLASSES) begin
      rd_data_q <= vec_q[rd_idx];
    end else begin
      rd_data_q <= vec_q[0];
    end
  end

  assign busy       = (state_q == SCAN);
  assign res_valid  = res_valid_q;
  assign res_class  = res_class_q;
  assign res_score  = res_score_q;
  assign res_margin = res_margin_q;
  assign in_drop    = drop_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_dnn_result_argmax.sv
// Self-checking bench for dnn_result_argmax with default parameters.
module tb_dnn_result_argmax;

  localparam int DW = 9;
  localparam int N  = 10;
  localparam int IW = 4;

  typedef int vec_t [N];

  logic            clk = 1'b0;
  logic            rst, clear, in_valid;
  logic [N*DW-1:0] in_vec;
  logic            busy, res_valid, in_drop;
  logic [IW-1:0]   res_class, rd_idx;
  logic [DW-1:0]   res_score, rd_data;
  logic [DW:0]     res_margin;

  int   checks = 0;
  int   errors = 0;
  vec_t mbuf;

  dnn_result_argmax #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_vec     (in_vec),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_class  (res_class),
    .res_score  (res_score),
    .res_margin (res_margin),
    .in_drop    (in_drop),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: maximum value, lowest index holding it, and the largest
  // value among all other positions.
  function automatic void ref_argmax(input vec_t v, output int cls, output int best,
                                     output int margin);
    int second;
    best = v[0];
    for (int i = 1; i < N; i++) if (v[i] > best) best = v[i];
    cls = -1;
    for (int i = 0; i < N; i++) if (cls < 0 && v[i] == best) cls = i;
    second = -1000000;
    for (int i = 0; i < N; i++) if (i != cls && v[i] > second) second = v[i];
    margin = best - second;
  endfunction

  task automatic drive_vec(input vec_t v);
    for (int i = 0; i < N; i++) in_vec[i*DW +: DW] = DW'(v[i]);
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after capture.
  task automatic send(input vec_t v);
    drive_vec(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic vec_t rand_vec(input bit narrow);
    vec_t v;
    for (int i = 0; i < N; i++)
      v[i] = narrow ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 511)) - 256;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_vec = '0; rd_idx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) mbuf[i] = 0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_status busy=%b res_valid=%b required 0 0", busy, res_valid);
    end
    checks++;
    if (res_class !== '0 || res_score !== '0 || res_margin !== '0) begin
      errors++; $display("FAIL reset_result class=%0d score=%0d margin=%0d required 0 0 0",
                         res_class, res_score, res_margin);
    end
    checks++;
    if (in_drop !== 1'b0 || rd_data !== '0) begin
      errors++; $display("FAIL reset_misc in_drop=%b rd_data=%0d required 0 0", in_drop, rd_data);
    end
    $display("txn reset done");
  endtask

  task automatic test_known_vectors();
    vec_t v;
    int   exp_cls [3]    = '{0, 4, 2};
    int   exp_score [3]  = '{50, 255, 37};
    int   exp_margin [3] = '{0, 511, 1};
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        for (int i = 0; i < N; i++) v[i] = 50;
        v[7] = -3;
      end else if (t == 1) begin
        for (int i = 0; i < N; i++) v[i] = -256;
        v[4] = 255;
      end else begin
        v = '{10, -5, 37, 2, 0, -100, 36, 1, 3, 4};
      end
      send(v);
      mbuf = v;
      for (int k = 1; k <= N; k++) begin
        checks++;
        if (busy !== (k < N) || res_valid !== (k == N)) begin
          errors++; $display("FAIL known_timing vec=%0d k=%0d busy=%b res_valid=%b required %b %b",
                             t, k, busy, res_valid, (k < N), (k == N));
        end
        if (k < N) @(negedge clk);
      end
      checks++;
      if (res_class !== IW'(exp_cls[t]) || res_score !== DW'(exp_score[t]) ||
          res_margin !== (DW+1)'(exp_margin[t])) begin
        errors++; $display("FAIL known_result vec=%0d got class=%0d score=%0d margin=%0d required %0d %0d %0d",
                           t, res_class, $signed(res_score), res_margin,
                           exp_cls[t], exp_score[t], exp_margin[t]);
      end
      $display("txn known vec=%0d class=%0d score=%0d margin=%0d", t, res_class,
               $signed(res_score), res_margin);
    end
  endtask

  task automatic test_readout();
    rd_idx = 4'd2;
    @(negedge clk);
    checks++;
    if (rd_data !== DW'(37)) begin
      errors++; $display("FAIL readout_idx2 got=%0d required 37", $signed(rd_data));
    end
    rd_idx = 4'd12;
    @(negedge clk);
    checks++;
    if (rd_data !== DW'(10)) begin
      errors++; $display("FAIL readout_idx12 got=%0d required 10", $signed(rd_data));
    end
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      @(negedge clk);
      checks++;
      if (rd_data !== DW'(mbuf[i])) begin
        errors++; $display("FAIL readout_sweep idx=%0d got=%0d required %0d", i, $signed(rd_data), mbuf[i]);
      end
    end
    $display("txn readout sweep done");
  endtask

  // Each new vector is sent the cycle the previous result appears (HOLD).
  task automatic test_random_back_to_back();
    vec_t v;
    int   cls, best, margin, j;
    for (int it = 0; it < 20; it++) begin
      v = rand_vec(it[0]);
      j = int'($urandom_range(0, N-1));
      ref_argmax(v, cls, best, margin);
      send(v);
      mbuf = v;
      rd_idx = IW'(j);
      for (int k = 1; k <= N; k++) begin
        checks++;
        if (busy !== (k < N) || res_valid !== (k == N)) begin
          errors++; $display("FAIL rand_timing it=%0d k=%0d busy=%b res_valid=%b required %b %b",
                             it, k, busy, res_valid, (k < N), (k == N));
        end
        if (k == 2) begin
          checks++;
          if (rd_data !== DW'(v[j])) begin
            errors++; $display("FAIL rand_scan_readout it=%0d idx=%0d got=%0d required %0d",
                               it, j, $signed(rd_data), v[j]);
          end
        end
        if (k < N) @(negedge clk);
      end
      checks++;
      if (res_class !== IW'(cls) || res_score !== DW'(best) || res_margin !== (DW+1)'(margin)) begin
        errors++; $display("FAIL rand_result it=%0d got class=%0d score=%0d margin=%0d required %0d %0d %0d",
                           it, res_class, $signed(res_score), res_margin, cls, best, margin);
      end
      $display("txn random it=%0d class=%0d score=%0d margin=%0d", it, cls, best, margin);
    end
  endtask

  task automatic test_drop();
    vec_t v1, v2;
    int   cls, best, margin, j;
    v1 = rand_vec(1'b0);
    v2 = rand_vec(1'b0);
    ref_argmax(v1, cls, best, margin);
    send(v1);                     // now in cycle t+1
    mbuf = v1;
    repeat (2) @(negedge clk);    // cycle t+3
    drive_vec(v2);
    in_valid = 1'b1;
    @(negedge clk);               // cycle t+4
    in_valid = 1'b0;
    checks++;
    if (in_drop !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_flag in_drop=%b busy=%b required 1 1", in_drop, busy);
    end
    repeat (6) @(negedge clk);    // cycle t+10
    checks++;
    if (res_valid !== 1'b1 || res_class !== IW'(cls) || res_score !== DW'(best) ||
        res_margin !== (DW+1)'(margin)) begin
      errors++; $display("FAIL drop_result valid=%b class=%0d score=%0d margin=%0d required 1 %0d %0d %0d",
                         res_valid, res_class, $signed(res_score), res_margin, cls, best, margin);
    end
    j = int'($urandom_range(0, N-1));
    rd_idx = IW'(j);
    repeat (3) @(negedge clk);
    checks++;
    if (rd_data !== DW'(v1[j])) begin
      errors++; $display("FAIL drop_buffer idx=%0d got=%0d required %0d", j, $signed(rd_data), v1[j]);
    end
    checks++;
    if (res_valid !== 1'b1 || res_class !== IW'(cls) || res_score !== DW'(best) || in_drop !== 1'b1) begin
      errors++; $display("FAIL hold_stable valid=%b class=%0d score=%0d drop=%b required 1 %0d %0d 1",
                         res_valid, res_class, $signed(res_score), in_drop, cls, best);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (in_drop !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_status drop=%b valid=%b busy=%b required 0 0 0", in_drop, res_valid, busy);
    end
    checks++;
    if (res_class !== '0 || res_score !== '0 || res_margin !== '0) begin
      errors++; $display("FAIL clear_result class=%0d score=%0d margin=%0d required 0 0 0",
                         res_class, res_score, res_margin);
    end
    $display("txn drop class=%0d score=%0d then clear", cls, best);
  endtask

  task automatic test_rst_mid_scan();
    vec_t v;
    v = rand_vec(1'b0);
    send(v);                      // cycle t+1
    repeat (4) @(negedge clk);    // cycle t+5
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) mbuf[i] = 0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL rst_abort busy=%b res_valid=%b required 0 0", busy, res_valid);
    end
    rd_idx = 4'd3;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_no_result cycle=%0d res_valid=%b busy=%b required 0 0", c, res_valid, busy);
      end
    end
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL rst_buffer got=%0d required 0", $signed(rd_data));
    end
    $display("txn reset mid-scan");
  endtask

  task automatic test_clear_in_valid();
    vec_t va, v2;
    va = rand_vec(1'b0);
    v2 = rand_vec(1'b0);
    v2[0] = (va[0] == 5) ? 6 : 5;
    send(va);
    mbuf = va;
    repeat (N-1) @(negedge clk);
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL clrin_setup res_valid=%b required 1", res_valid);
    end
    drive_vec(v2);
    clear = 1'b1;
    in_valid = 1'b1;
    rd_idx = '0;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || in_drop !== 1'b0 || res_class !== '0) begin
      errors++; $display("FAIL clrin_status busy=%b valid=%b drop=%b class=%0d required 0 0 0 0",
                         busy, res_valid, in_drop, res_class);
    end
    @(negedge clk);
    checks++;
    if (rd_data !== DW'(mbuf[0])) begin
      errors++; $display("FAIL clrin_buffer got=%0d required %0d", $signed(rd_data), mbuf[0]);
    end
    repeat (N) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clrin_idle res_valid=%b busy=%b required 0 0", res_valid, busy);
    end
    $display("txn clear with in_valid");
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_readout();
    test_random_back_to_back();
    test_drop();
    test_rst_mid_scan();
    test_clear_in_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dnn_result_argmax.md
DNN_RESULT_ARGMAX -- requirements
Module: dnn_result_argmax

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, meaning signed width of each class score.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, meaning number of output scores; legal range 2..64.
REQ-003 SHALL have derived parameter IDX_WIDTH, default $clog2(NUM_CLASSES), meaning width of class indices.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous soft clear of result and status.
REQ-007 SHALL have port in_valid  input  1  one-cycle pulse (engine done) qualifying in_vec.
REQ-008 SHALL have port in_vec  input  NUM_CLASSES x DATA_WIDTH signed  score vector from the inference engine.
REQ-009 SHALL have port busy  output  1  high while scanning.
REQ-010 SHALL have port res_valid  output  1  high while a completed result is held.
REQ-011 SHALL have port res_class  output  IDX_WIDTH unsigned  index of maximum score.
REQ-012 SHALL have port res_score  output  DATA_WIDTH signed  maximum score.
REQ-013 SHALL have port res_margin  output  DATA_WIDTH+1 unsigned  best minus second-best score.
REQ-014 SHALL have port in_drop  output  1  sticky flag: in_valid arrived while busy.
REQ-015 SHALL have port rd_idx  input  IDX_WIDTH unsigned  readout select into captured vector.
REQ-016 SHALL have port rd_data  output  DATA_WIDTH signed  registered captured score at rd_idx.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN, HOLD.
REQ-018 In IDLE or HOLD, in_valid SHALL capture in_vec into an internal buffer, load best=buf[0], best_idx=0, second=most-negative value, counter=1, enter SCAN, drop res_valid next cycle.
REQ-019 In SCAN, one element buf[counter] SHALL be compared per cycle; counter increments by 1.
REQ-020 Compare rule: x > best -> second=best, best=x, best_idx=counter; else x > second -> second=x; equality never replaces (ties resolve to lowest index).
REQ-021 After comparing element NUM_CLASSES-1, FSM SHALL enter HOLD; in_valid at cycle t yields res_valid=1 at cycle t+NUM_CLASSES.
REQ-022 res_class, res_score, res_margin SHALL be stable while res_valid=1 and update only on SCAN->HOLD.
REQ-023 res_margin SHALL be computed at DATA_WIDTH+1 bits so it never overflows (max 2^DATA_WIDTH-1).
REQ-024 busy SHALL equal (state==SCAN).
REQ-025 in_valid during SCAN SHALL be ignored (buffer and scan untouched) and SHALL set in_drop.
REQ-026 clear SHALL force IDLE, res_valid=0, res_* to 0, in_drop=0; buffer contents retained.
REQ-027 clear and in_valid in the same cycle: clear wins, input discarded, in_drop not set.
REQ-028 rd_data SHALL equal buf[rd_idx] one cycle after rd_idx is presented; rd_idx >= NUM_CLASSES returns buf[0].
REQ-029 Readout SHALL be available in every state, including during SCAN (returns newly captured values).

Reset
REQ-030 rst SHALL force IDLE, busy=0, res_valid=0, res_class=0, res_score=0, res_margin=0, in_drop=0, rd_data=0, counter=0.
REQ-031 rst SHALL clear the buffer to 0 and has priority over clear and in_valid.
REQ-032 rst asserted mid-SCAN SHALL abort the scan with no res_valid pulse afterward.

Structure
REQ-033 Shared package dnn_pkg SHALL hold default DATA_WIDTH, NUM_CLASSES and the FSM state enum typedef.
REQ-034 Compare-and-update logic SHALL be one combinational sub-module, argmax_top2_update (inputs x, idx, best, best_idx, second; outputs updated triple).
REQ-035 Module SHALL contain no latches; all outputs registered except busy.

Verification
REQ-036 Defaults, in_vec={10,-5,37,2,0,-100,36,1,3,4}, in_valid pulse at t -> res_valid at t+10, res_class=2, res_score=37, res_margin=1.
REQ-037 Ties: in_vec all 50 except [7]=-3 -> res_class=0, res_score=50, res_margin=0.
REQ-038 Extremes: [4]=255, [9]=-256, others -256 -> res_class=4, res_margin=511, no overflow.
REQ-039 Second in_valid at t+3 during SCAN -> ignored, first result unchanged, in_drop=1 until clear.
REQ-040 rst at t+5 mid-SCAN -> busy=0 next cycle, res_valid stays 0; clear+in_valid same cycle -> IDLE, in_drop=0.
REQ-041 Readout: rd_idx=2 -> rd_data=37 one cycle later; rd_idx=12 -> rd_data=buf[0]=10.
